// File: rtl/txrx_tx_seq_pkg.sv
// Shared TXRX definitions: register map (common with the slave), sequencer state encoding, field widths.
package txrx_tx_seq_pkg;

    localparam int CH_IDX_W = 6;

    localparam logic [4:0] TX_EN       = 5'h00;
    localparam logic [4:0] TX_START    = 5'h01;
    localparam logic [4:0] TX_DATA     = 5'h02;
    localparam logic [4:0] TXRX_AA     = 5'h03;
    localparam logic [4:0] TXRX_CH_IDX = 5'h04;
    localparam logic [4:0] TX_READY    = 5'h05;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_W_AA  = 4'd1,
        S_W_CH  = 4'd2,
        S_W_EN  = 4'd3,
        S_PUSH  = 4'd4,
        S_W_ST1 = 4'd5,
        S_W_ST0 = 4'd6,
        S_WAIT  = 4'd7,
        S_POLL  = 4'd8,
        S_W_DIS = 4'd9,
        S_FIN   = 4'd10
    } seq_state_t;

endpackage

// File: rtl/txrx_tx_seq_if.sv
// TXRX register bus: initiator drives valid/address/wdata/wstrb, slave answers with a one-cycle ready and rdata.
interface txrx_tx_seq_if #(
    parameter int ADDR_W = 5
);
    logic              valid;
    logic [ADDR_W-1:0] address;
    logic [31:0]       wdata;
    logic              wstrb;
    logic [31:0]       rdata;
    logic              ready;

    modport master (output valid, address, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/txrx_byte_fifo.sv
// Single-clock byte FIFO; rd_dat shows the head combinationally, pop/push take effect at the clock edge.
// A push is accepted when full only if a pop happens in the same cycle.
module txrx_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_dat,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_dat  = mem[rd_ptr];
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/txrx_tx_seq.sv
// Runs one TXRX transmit (AA, CH, EN, data bytes, START pulse, TX_READY polling, disable) as bus initiator.
// Each register access is 2 bus cycles plus 1 idle; an empty byte FIFO stalls PUSH with the bus idle.
module txrx_tx_seq
    import txrx_tx_seq_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int LEN_W      = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int POLL_GAP   = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic [31:0]         aa,
    input  logic [CH_IDX_W-1:0] ch_idx,
    input  logic [LEN_W-1:0]    len,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    txrx_tx_seq_if.master       m
);
    localparam int PCW = $clog2(TIMEOUT + 1);
    localparam int GCW = $clog2(POLL_GAP + 1);

    seq_state_t                 state;
    seq_state_t                 nxt;
    logic [31:0]                aa_q;
    logic [CH_IDX_W-1:0]        ch_q;
    logic [LEN_W-1:0]           byte_cnt;
    logic [PCW-1:0]             poll_cnt;
    logic [GCW-1:0]             gap_cnt;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_pop;
    logic [7:0]                 fifo_dat;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                       is_bus;
    logic                       issue;
    logic [4:0]                 req_addr;
    logic [31:0]                req_dat;
    logic                       req_wr;
    logic                       rdata_unused;

    assign rdata_unused = ^{m.rdata[31:1], fifo_count};
    assign byte_ready   = !fifo_full;
    assign is_bus       = (state != S_IDLE) && (state != S_WAIT) && (state != S_FIN);
    assign issue        = is_bus && !m.valid && ((state != S_PUSH) || !fifo_empty);
    assign fifo_pop     = issue && (state == S_PUSH);

    txrx_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (byte_valid && !fifo_full),
        .wr_dat (byte_in),
        .rd_en  (fifo_pop),
        .rd_dat (fifo_dat),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Request contents and successor state for whichever register access the current state owns.
    always_comb begin
        req_addr = TX_EN;
        req_dat  = '0;
        req_wr   = 1'b1;
        nxt      = state;
        case (state)
            S_W_AA:  begin req_addr = TXRX_AA;     req_dat = aa_q;                  nxt = S_W_CH; end
            S_W_CH:  begin req_addr = TXRX_CH_IDX; req_dat = {26'b0, ch_q};         nxt = S_W_EN; end
            S_W_EN:  begin req_addr = TX_EN;       req_dat = 32'd1;
                           nxt = (byte_cnt == '0) ? S_W_ST1 : S_PUSH; end
            S_PUSH:  begin req_addr = TX_DATA;     req_dat = {24'b0, fifo_dat};
                           nxt = (byte_cnt == LEN_W'(1)) ? S_W_ST1 : S_PUSH; end
            S_W_ST1: begin req_addr = TX_START;    req_dat = 32'd1;                 nxt = S_W_ST0; end
            S_W_ST0: begin req_addr = TX_START;    req_dat = 32'd0;                 nxt = S_WAIT; end
            S_POLL:  begin req_addr = TX_READY;    req_wr  = 1'b0;
                           nxt = (m.rdata[0] || (poll_cnt == PCW'(TIMEOUT - 1))) ? S_W_DIS : S_WAIT; end
            S_W_DIS: begin req_addr = TX_EN;       req_dat = 32'd0;                 nxt = S_FIN; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            m.valid   <= 1'b0;
            m.address <= '0;
            m.wdata   <= '0;
            m.wstrb   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            aa_q      <= '0;
            ch_q      <= '0;
            byte_cnt  <= '0;
            poll_cnt  <= '0;
            gap_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (go) begin
                    aa_q     <= aa;
                    ch_q     <= ch_idx;
                    byte_cnt <= len;
                    poll_cnt <= '0;
                    err      <= 1'b0;
                    busy     <= 1'b1;
                    state    <= S_W_AA;
                end
                S_WAIT: begin
                    if (gap_cnt == GCW'(POLL_GAP - 1)) state <= S_POLL;
                    else gap_cnt <= gap_cnt + 1'b1;
                end
                S_FIN: state <= S_IDLE;
                default: begin
                    if (issue) begin
                        m.valid   <= 1'b1;
                        m.address <= ADDR_W'(req_addr);
                        m.wdata   <= req_dat;
                        m.wstrb   <= req_wr;
                    end else if (m.valid && m.ready) begin
                        // Dropping valid here guarantees the idle cycle before the next access.
                        m.valid <= 1'b0;
                        m.wstrb <= 1'b0;
                        state   <= nxt;
                        if (state == S_PUSH) byte_cnt <= byte_cnt - 1'b1;
                        if (state == S_POLL && !m.rdata[0]) begin
                            poll_cnt <= poll_cnt + 1'b1;
                            if (poll_cnt == PCW'(TIMEOUT - 1)) err <= 1'b1;
                        end
                        if (nxt == S_WAIT) gap_cnt <= '0;
                        if (nxt == S_FIN) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_txrx_tx_seq.sv
// Directed bench for txrx_tx_seq: slave model logs bus accesses, a monitor checks the handshake every cycle.
module tb_txrx_tx_seq;
    import txrx_tx_seq_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] dat;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go = 1'b0;
    logic [31:0] aa = '0;
    logic [5:0]  ch_idx = '0;
    logic [5:0]  len = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready, busy, done, err;

    int errors = 0;
    int checks = 0;
    int ready_on = 0;
    int rd_num = 0;
    int rd_base = 0;
    logic s_ready = 1'b0;
    ev_t log_q[$];
    ev_t exp_q[$];
    logic       pv = 1'b0, pr = 1'b0;
    logic [4:0] pa = '0;

    txrx_tx_seq_if #(.ADDR_W(5)) bus ();

    txrx_tx_seq #(.ADDR_W(5), .LEN_W(6), .FIFO_DEPTH(8), .POLL_GAP(4), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .go(go), .aa(aa), .ch_idx(ch_idx), .len(len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .done(done), .err(err), .m(bus)
    );

    always #5 clk = ~clk;

    // Slave: ready one cycle after a new request, TX_READY reads report ready from read number ready_on.
    assign bus.ready = s_ready;
    assign bus.rdata = {31'b0, (ready_on != 0) && ((rd_num - rd_base) >= ready_on)};

    always @(posedge clk) begin
        if (!rst) begin
            s_ready <= 1'b0;
        end else begin
            s_ready <= bus.valid && !s_ready;
            if (bus.valid && !s_ready) begin
                log_q.push_back({bus.wstrb, bus.address, bus.wstrb ? bus.wdata : 32'h0});
                if (!bus.wstrb) rd_num <= rd_num + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (pv || bus.valid) begin
                checks++;
                assert (!(pv && pr && bus.valid) && !(pv && !pr && !bus.valid) &&
                        !(pv && !pr && bus.address != pa))
                else begin
                    errors++;
                    $error("FAIL proto: valid=%b addr=%h prev_valid=%b prev_ready=%b prev_addr=%h",
                           bus.valid, bus.address, pv, pr, pa);
                end
            end
            pv = bus.valid;
            pr = bus.ready;
            pa = bus.address;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic ew(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({1'b1, a, d});
    endtask

    task automatic er(input logic [4:0] a);
        exp_q.push_back({1'b0, a, 32'h0});
    endtask

    task automatic cmp_log(input string tag);
        chk({tag, " count"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s access %0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        byte_in = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic start(input logic [31:0] a, input logic [5:0] c, input logic [5:0] l);
        rd_base = rd_num;
        aa = a;
        ch_idx = c;
        len = l;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input logic exp_err);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done"}, 64'(done), 64'(1));
        chk({tag, " err"}, 64'(err), 64'(exp_err));
        @(negedge clk);
        chk({tag, " done pulse"}, 64'(done), 64'(0));
        chk({tag, " idle busy"}, 64'(busy), 64'(0));
    endtask

    task automatic exp_head(input logic [31:0] a, input logic [5:0] c);
        ew(TXRX_AA, a);
        ew(TXRX_CH_IDX, {26'b0, c});
        ew(TX_EN, 32'd1);
    endtask

    task automatic exp_start;
        ew(TX_START, 32'd1);
        ew(TX_START, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst valid", 64'(bus.valid), 64'(0));
        chk("rst addr", 64'(bus.address), 64'(0));
        chk("rst wdata", 64'(bus.wdata), 64'(0));
        chk("rst wstrb", 64'(bus.wstrb), 64'(0));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst err", 64'(err), 64'(0));
        chk("rst byte_ready", 64'(byte_ready), 64'(1));
        rst = 1'b1;
        @(negedge clk);

        // Preloaded 3-byte packet, ready on 2nd poll, with an ignored go mid-sequence.
        ready_on = 2;
        push_byte(8'hA1);
        push_byte(8'hB2);
        push_byte(8'hC3);
        start(32'h8E89BED6, 6'd37, 6'd3);
        chk("t1 busy", 64'(busy), 64'(1));
        repeat (4) @(negedge clk);
        aa = 32'h12345678; ch_idx = 6'd1; len = 6'd9; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_done("t1", 400, 1'b0);
        exp_head(32'h8E89BED6, 6'd37);
        ew(TX_DATA, 32'hA1); ew(TX_DATA, 32'hB2); ew(TX_DATA, 32'hC3);
        exp_start();
        er(TX_READY); er(TX_READY);
        ew(TX_EN, 32'd0);
        cmp_log("t1");

        // Zero-length packet.
        ready_on = 1;
        start(32'h00000001, 6'd2, 6'd0);
        wait_done("t2", 400, 1'b0);
        exp_head(32'h00000001, 6'd2);
        exp_start();
        er(TX_READY);
        ew(TX_EN, 32'd0);
        cmp_log("t2");

        // Slave never ready: 4 polls then abort; next go clears err.
        ready_on = 0;
        start(32'hDEADBEEF, 6'd63, 6'd0);
        wait_done("t3", 600, 1'b1);
        exp_head(32'hDEADBEEF, 6'd63);
        exp_start();
        for (int i = 0; i < 4; i++) er(TX_READY);
        ew(TX_EN, 32'd0);
        cmp_log("t3");
        ready_on = 1;
        start(32'h0, 6'd0, 6'd0);
        chk("t3 err cleared", 64'(err), 64'(0));
        wait_done("t3b", 400, 1'b0);
        log_q.delete();

        // Slow byte source: PUSH must stall with the bus idle.
        start(32'h55AA55AA, 6'd10, 6'd5);
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    repeat (20) @(negedge clk);
                    chk($sformatf("t4 stall %0d", i), 64'(bus.valid), 64'(0));
                    push_byte(8'(8'h11 * (i + 1)));
                end
            end
            wait_done("t4", 600, 1'b0);
        join
        exp_head(32'h55AA55AA, 6'd10);
        for (int i = 0; i < 5; i++) ew(TX_DATA, 32'(8'h11 * (i + 1)));
        exp_start();
        er(TX_READY);
        ew(TX_EN, 32'd0);
        cmp_log("t4");

        // Reset during PUSH after two data writes, then a clean sequence.
        for (int i = 0; i < 4; i++) push_byte(8'(8'h41 + i));
        start(32'h13572468, 6'd7, 6'd4);
        begin
            int n = 0;
            while (log_q.size() < 5 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t5 reached push", 64'(log_q.size()), 64'(5));
        rst = 1'b0;
        @(negedge clk);
        chk("t5 valid", 64'(bus.valid), 64'(0));
        chk("t5 busy", 64'(busy), 64'(0));
        chk("t5 byte_ready", 64'(byte_ready), 64'(1));
        chk("t5 fifo empty", 64'(dut.u_fifo.empty), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        log_q.delete();
        push_byte(8'h5A);
        start(32'hCAFEF00D, 6'd5, 6'd1);
        wait_done("t5", 400, 1'b0);
        exp_head(32'hCAFEF00D, 6'd5);
        ew(TX_DATA, 32'h5A);
        exp_start();
        er(TX_READY);
        ew(TX_EN, 32'd0);
        cmp_log("t5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/txrx_tx_seq.md
Name: txrx_tx_seq

Overview:
- Hardware bus initiator that drives the TXRX peripheral's register interface: valid, address, wdata, wstrb, rdata and ready.
- It runs one complete transmit with no CPU involvement:
  - program the access address and channel index;
  - enable TX;
  - push the packet bytes;
  - pulse start;
  - poll until TX reports ready;
  - disable TX.
- It sits between a packet source (byte stream from a DMA or a local engine) and the TXRX slave port.
- It replaces CPU polling loops in firmware.

Parameters:
- ADDR_W, 5, width of the peripheral address bus.
- LEN_W, 6, width of the packet length field; maximum 63 bytes.
- FIFO_DEPTH, 8, depth of the input byte FIFO (power of 2).
- POLL_GAP, 16, idle cycles between successive TX_READY reads.
- TIMEOUT, 4096, maximum number of TX_READY polls before the sequence aborts.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- go  in  1  single-cycle start request; ignored unless idle.
- aa  in  32  access address, latched on go.
- ch_idx  in  6  channel index, latched on go.
- len  in  LEN_W  byte count, latched on go.
- byte_in  in  8  packet byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  FIFO not full.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky timeout flag; cleared on the next accepted go.
- m_valid  out  1  bus request.
- m_address  out  ADDR_W  register address.
- m_wdata  out  32  write data.
- m_wstrb  out  1  1 = write, 0 = read.
- m_rdata  in  32  read data; valid while m_ready=1.
- m_ready  in  1  slave acknowledge; registered copy of m_valid, so one cycle of latency.

Behaviour:
- Reset (rst=0 at a clk edge) takes effect mid-operation too. It forces:
  - state IDLE; FIFO emptied;
  - m_valid=0, m_wstrb=0, m_address=0, m_wdata=0;
  - busy=0, done=0, err=0, byte_ready=1.
- Bus transaction rules:
  - Cycle T: assert m_valid with m_address, m_wdata and m_wstrb stable.
  - Hold everything until m_ready=1.
  - In the m_ready cycle, capture m_rdata (reads only), then drop m_valid.
  - m_valid stays 0 for at least one cycle between transactions. This prevents repeated writes, because the slave writes on every valid&wstrb cycle.
  - Minimum transaction length is 2 cycles plus 1 idle cycle.
- FIFO:
  - Push when byte_valid & byte_ready. Pop during the PUSH state.
  - Bytes may be pushed while IDLE, so a packet can be preloaded.
  - A push and a pop in the same cycle when full is allowed; the count stays the same.
- FSM states and writes, in order:
  - IDLE: on go, latch aa, ch_idx and len, clear err, set busy=1, go to W_AA.
  - W_AA: write TXRX_AA ← aa.
  - W_CH: write TXRX_CH_IDX ← {26'b0, ch_idx}.
  - W_EN: write TX_EN ← 1.
  - PUSH: for each remaining byte, wait for the FIFO to be non-empty, then write TX_DATA ← {24'b0, byte}.
    - A byte counter counts down from len.
    - len=0 skips PUSH.
    - An empty FIFO stalls with m_valid=0; there is no timeout in this state.
  - W_ST1: write TX_START ← 1.
  - W_ST0: write TX_START ← 0. This re-arms the slave's edge detector.
  - WAIT: count POLL_GAP cycles.
  - POLL: read TX_READY.
    - m_rdata[0]=1: go to W_DIS.
    - Otherwise increment the poll counter and return to WAIT.
    - When the counter reaches TIMEOUT: set err=1, go to W_DIS.
  - W_DIS: write TX_EN ← 0.
  - FIN: pulse done=1 for one cycle, set busy=0, return to IDLE.
- The done pulse is issued on both success and timeout; err distinguishes the two.
- go while busy is ignored and has no side effects.
- Register addresses (TX_EN, TX_START, TX_DATA, TXRX_AA, TXRX_CH_IDX, TX_READY) come from the shared txrx header constants.

Decomposition:
- Shared header: register address macros (already shared with the slave), an FSM state encoding localparam set, and CH_IDX_W=6.
- Sub-module txrx_byte_fifo: synchronous single-clock FIFO, FIFO_DEPTH×8, with full/empty outputs and a count. It reuses the same rst polarity.

Test Plan:
- Preload bytes 0xA1,0xB2,0xC3; go with aa=0x8E89BED6, ch_idx=37, len=3; the slave model returns TX_READY=1 on the 2nd poll. Required:
  - write sequence AA=0x8E89BED6, CH=37, EN=1, DATA A1,B2,C3, START=1, START=0, 2 reads, EN=0;
  - done after FIN; err=0.
- len=0 → no TX_DATA writes; all other writes occur in order; done=1.
- Slave never reports ready, TIMEOUT=4 → exactly 4 TX_READY reads, then EN=0 written, err=1, done=1. A following go clears err.
- len=5 with bytes fed 1 per 20 cycles → PUSH stalls with m_valid=0 and no bus activity; all 5 bytes are written in order.
- Protocol check in all tests: every m_valid high interval ends exactly 1 cycle after m_ready, and m_valid is low at least 1 cycle between transactions. go while busy → no change.
- Assert rst=0 during PUSH after 2 of 4 bytes → next cycle m_valid=0, busy=0, FIFO empty. A new go performs a full sequence from W_AA.
